// File: rtl/riscv_inst_prefetch.sv
// Instruction prefetch queue between the instruction memory port and decode.
// Issues sequential word fetches to a pipelined in-order memory (req/gnt/rvalid),
// buffers up to DEPTH returned words tagged with their PC, and on a redirect
// flushes the queue and discards responses that are still in flight.
module riscv_inst_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [31:0]   redirect_word;
  logic [CW:0]   in_use;
  logic          grant;
  logic          rsp_ok;
  logic          push;
  logic          pop;

  assign redirect_word = redirect_pc_i & ~32'h3;
  assign in_use        = {1'b0, count} + {1'b0, outstanding};

  // A fetch may only be issued while every slot it could land in is free.
  assign mem_req_o    = !rst && !redirect_i && (in_use < DEPTH_W);
  assign mem_addr_o   = fetch_pc;
  assign grant        = mem_req_o && mem_gnt_i;

  // An rvalid with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok       = mem_rvalid_i && (outstanding != '0);
  assign push         = rsp_ok && (drop == '0) && !redirect_i;

  assign inst_valid_o = (count != '0);
  assign pop          = inst_valid_o && inst_ready_i && !redirect_i;
  assign inst_o       = inst_mem[rd_ptr];
  assign inst_pc_o    = pc_mem[rd_ptr];

  // Fetch address: restart on redirect, advance one word per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= redirect_word;
    end else if (grant) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // PC tag for the next kept response: follows the redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_pc <= RESET_PC;
    end else if (redirect_i) begin
      resp_pc <= redirect_word;
    end else if (push) begin
      resp_pc <= resp_pc + 32'd4;
    end
  end

  // Track requests in flight and how many of them belong to an abandoned stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      drop        <= '0;
    end else begin
      case ({grant, rsp_ok})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      // drop is always a subset of outstanding, so on a redirect every response
      // still in flight (less one returning now) becomes stale.
      if (redirect_i) begin
        drop <= outstanding - CW'(rsp_ok);
      end else if (rsp_ok && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
    end
  end

  // Queue occupancy and pointers; a redirect empties the queue and cancels push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_i) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered queue storage: instruction word and its PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      inst_mem[wr_ptr] <= mem_rdata_i;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_riscv_inst_prefetch.sv
// Scoreboard bench for riscv_inst_prefetch: expected {pc} per consumed head entry
// is queued by the stimulus; a monitor pops and compares on every consumption.
module tb_riscv_inst_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i    = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i  = 32'h0;

  riscv_inst_prefetch #(.DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          pop_cnt = 0;
  int          gnt_cnt = 0;
  int          cyc = 0;
  int          lat = 1;
  logic        gnt_en = 1'b1;
  logic [31:0] exp_q [$];
  pend_t       pend [$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: in-order pipeline with fixed latency, grant gated by gnt_en.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      pend.delete();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        pend_t p;
        p = pend.pop_front();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = memf(p.addr);
      end
      mem_gnt_i = gnt_en && mem_req_o;
      if (gnt_en && mem_req_o) begin
        pend.push_back('{mem_addr_o, cyc + lat});
        gnt_cnt++;
      end
    end
  end

  // Monitor: every head consumption is compared against the scoreboard.
  always @(negedge clk) begin
    #3;
    if (!rst && inst_valid_o && inst_ready_i && !redirect_i) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pop: got pc %h expected none", inst_pc_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("head_pc", inst_pc_o, e);
        chk("head_inst", inst_o, memf(e));
      end
    end
  end

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
  endtask

  // Run until every expected entry is consumed, then stop consuming.
  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        inst_ready_i = 1'b0;
        chk("drain", 32'd0, 32'(exp_q.size()));
        return;
      end
    end
    inst_ready_i = 1'b0;
    chk("drain_timeout_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; inst_ready_i = 1'b1;

    // 1: reset state, first fetch, latency and throughput
    tick(); tick(); #4;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", inst_pc_o, 32'h0);
    chk("rst_addr", mem_addr_o, 32'h100);
    push_seq(32'h100, 16);
    tick(); rst = 1'b0; #4;
    chk("first_req", 32'(mem_req_o), 32'd1);
    chk("first_addr", mem_addr_o, 32'h100);
    chk("lat_valid_c0", 32'(inst_valid_o), 32'd0);
    tick(); #4;
    chk("lat_valid_c1", 32'(inst_valid_o), 32'd0);
    tick(); #4;
    chk("lat_valid_c2", 32'(inst_valid_o), 32'd1);
    chk("lat_pc_c2", inst_pc_o, 32'h100);
    p0 = pop_cnt;
    repeat (8) tick();
    #4;
    chk("throughput", 32'(pop_cnt - p0), 32'd8);
    tick(); inst_ready_i = 1'b0;

    // 2: backpressure fills exactly DEPTH entries
    lat = 1;
    gnt_cnt = 0;
    do_reset();
    gnt_cnt = 0;
    push_seq(32'h100, 8);
    tick(); rst = 1'b0;
    repeat (7) tick();
    #4;
    chk("bp_grants", 32'(gnt_cnt), 32'd4);
    chk("bp_req", 32'(mem_req_o), 32'd0);
    chk("bp_valid", 32'(inst_valid_o), 32'd1);
    chk("bp_head_pc", inst_pc_o, 32'h100);
    tick(); inst_ready_i = 1'b1; #4;
    chk("bp_req_ready_cycle", 32'(mem_req_o), 32'd0);
    tick(); #4;
    chk("bp_resume_req", 32'(mem_req_o), 32'd1);
    chk("bp_resume_addr", mem_addr_o, 32'h110);
    wait_empty(40);

    // 3: redirect with three fetches in flight
    do_reset();
    inst_ready_i = 1'b1;
    lat = 4;
    tick(); rst = 1'b0;
    tick(); tick(); tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h2002;
    exp_q.delete();
    push_seq(32'h2000, 8);
    #4;
    chk("rd3_req_in_redirect", 32'(mem_req_o), 32'd0);
    tick(); redirect_i = 1'b0; #4;
    chk("rd3_req", 32'(mem_req_o), 32'd1);
    chk("rd3_addr", mem_addr_o, 32'h2000);
    wait_empty(80);

    // 4: redirect coincident with rvalid and pop
    do_reset();
    inst_ready_i = 1'b1;
    lat = 2;
    push_seq(32'h100, 4);
    tick(); rst = 1'b0;
    repeat (6) tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h3000;
    exp_q.delete();
    push_seq(32'h3000, 4);
    #4;
    chk("rd4_rvalid", 32'(mem_rvalid_i), 32'd1);
    chk("rd4_valid_before", 32'(inst_valid_o), 32'd1);
    chk("rd4_head_before", inst_pc_o, 32'h10C);
    tick(); redirect_i = 1'b0; #4;
    chk("rd4_valid_c1", 32'(inst_valid_o), 32'd0);
    chk("rd4_addr", mem_addr_o, 32'h3000);
    tick(); #4;
    chk("rd4_valid_c2", 32'(inst_valid_o), 32'd0);
    tick(); #4;
    chk("rd4_valid_c3", 32'(inst_valid_o), 32'd0);
    wait_empty(40);

    // 5: grant stall keeps request and address stable
    do_reset();
    inst_ready_i = 1'b1;
    lat = 1;
    gnt_en = 1'b0;
    push_seq(32'h100, 8);
    tick(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) tick();
      #4;
      chk("stall_req", 32'(mem_req_o), 32'd1);
      chk("stall_addr", mem_addr_o, 32'h100);
    end
    tick(); gnt_en = 1'b1; #4;
    chk("stall_gnt_addr", mem_addr_o, 32'h100);
    tick(); gnt_en = 1'b0; #4;
    chk("stall_next_addr", mem_addr_o, 32'h104);
    chk("stall_next_req", 32'(mem_req_o), 32'd1);
    tick(); gnt_en = 1'b1;
    wait_empty(40);

    // 6: address wrap, then asynchronous reset mid-burst
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; inst_ready_i = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFFC);
    push_seq(32'h0, 3);
    #4;
    chk("wrap_req_in_redirect", 32'(mem_req_o), 32'd0);
    tick(); redirect_i = 1'b0; #4;
    chk("wrap_addr0", mem_addr_o, 32'hFFFF_FFFC);
    chk("wrap_req", 32'(mem_req_o), 32'd1);
    tick(); #4;
    chk("wrap_addr1", mem_addr_o, 32'h0);
    tick(); tick(); tick();
    #1;
    chk("burst_req", 32'(mem_req_o), 32'd1);
    chk("burst_valid", 32'(inst_valid_o), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_req", 32'(mem_req_o), 32'd0);
    chk("async_valid", 32'(inst_valid_o), 32'd0);
    chk("async_inst", inst_o, 32'h0);
    chk("async_pc", inst_pc_o, 32'h0);
    chk("async_addr", mem_addr_o, 32'h100);
    tick(); tick(); #4;
    chk("held_rst_req", 32'(mem_req_o), 32'd0);
    tick(); rst = 1'b0; inst_ready_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
